lvds_line_buffer: RTL and testbench

LVDS_LINE_BUFFER -- requirements
Module: lvds_line_buffer

---
 rtl/lvds_line_buffer.sv | 169 ++++++++++++++++
 tb/tb_lvds_line_buffer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_line_buffer.sv
// Double-banked line buffer between a pixel stream and the LVDS slot timing.
// One bank is filled with the incoming line while the other is scanned out
// pair by pair at the slot index supplied by the LVDS timing generator.
module lvds_line_buffer #(
  parameter int H_PAIRS = 960,
  parameter int PIX_W   = 24
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [PIX_W-1:0] i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_in_sol,
  input  logic             i_in_eol,
  input  logic             i_line_start,
  input  logic [11:0]      i_x,
  output logic [PIX_W-1:0] o_color,
  output logic [PIX_W-1:0] o_color_even,
  output logic             o_underflow,
  output logic             o_sync_err
);

  localparam int CW = $clog2(2*H_PAIRS + 1);
  localparam int MW = $clog2(2*H_PAIRS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam logic [CW-1:0] LAST_COUNT = CW'(2*H_PAIRS - 1);
  localparam logic [11:0]   X_LIMIT    = 12'(H_PAIRS);
  localparam logic [MW-1:0] BANK1_BASE = MW'(H_PAIRS);

  // Both banks live in one array: bank 0 at [0, H_PAIRS), bank 1 above it.
  logic [2*PIX_W-1:0] mem [0:2*H_PAIRS-1];

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic             wr_bank;
  logic [PIX_W-1:0] hold;
  logic [1:0]       full;
  logic             rd_valid;
  logic             rd_bank;

  logic [1:0]       free;
  logic             sel_bank;
  logic             rd_cand;
  logic             xfer;
  logic             mem_we;
  logic [MW-1:0]    wr_idx;
  logic [MW-1:0]    rd_idx;

  // Bank availability, handshake and address generation.
  always_comb begin
    free[0]  = !full[0] && !(rd_valid && !rd_bank);
    free[1]  = !full[1] && !(rd_valid && rd_bank);
    sel_bank = !free[0];
    // With a read bank the candidate is the other bank; without one, the lowest full bank.
    rd_cand  = rd_valid ? !rd_bank : !full[0];

    o_in_ready = 1'b0;
    if (!i_reset) begin
      case (state)
        ST_IDLE: o_in_ready = |free;
        ST_FILL: o_in_ready = 1'b1;
        ST_DROP: o_in_ready = 1'b1;
        default: o_in_ready = 1'b0;
      endcase
    end

    xfer   = i_in_valid && o_in_ready;
    mem_we = xfer && (state == ST_FILL) && count[0] && !i_in_sol;
    wr_idx = MW'(count >> 1) + (wr_bank ? BANK1_BASE : '0);
    rd_idx = MW'(i_x) + (rd_bank ? BANK1_BASE : '0);
  end

  // Pair storage: the odd pixel completes a pair together with the held even pixel.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[wr_idx] <= {hold, i_in_data};
    end
  end

  // Registered scan-out of the read bank; blank outside the active pairs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_color      <= '0;
      o_color_even <= '0;
    end else if (rd_valid && (i_x < X_LIMIT)) begin
      {o_color, o_color_even} <= mem[rd_idx];
    end else begin
      o_color      <= '0;
      o_color_even <= '0;
    end
  end

  // Write FSM, bank ownership and sticky error flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      count       <= '0;
      wr_bank     <= 1'b0;
      hold        <= '0;
      full        <= 2'b00;
      rd_valid    <= 1'b0;
      rd_bank     <= 1'b0;
      o_underflow <= 1'b0;
      o_sync_err  <= 1'b0;
    end else begin
      if (i_line_start) begin
        if (rd_valid) begin
          full[rd_bank] <= 1'b0;
        end
        rd_bank  <= rd_cand;
        rd_valid <= full[rd_cand];
        if (!full[rd_cand]) begin
          o_underflow <= 1'b1;
        end
      end

      if (xfer) begin
        case (state)
          ST_IDLE: begin
            if (i_in_sol) begin
              wr_bank <= sel_bank;
              hold    <= i_in_data;
              count   <= CW'(1);
              state   <= ST_FILL;
            end
          end
          ST_FILL: begin
            if (i_in_sol) begin
              o_sync_err <= 1'b1;
              hold       <= i_in_data;
              count      <= CW'(1);
            end else if (i_in_eol) begin
              count <= '0;
              state <= ST_IDLE;
              if (count == LAST_COUNT) begin
                full[wr_bank] <= 1'b1;
              end else begin
                o_sync_err <= 1'b1;
              end
            end else if (count == LAST_COUNT) begin
              o_sync_err <= 1'b1;
              count      <= '0;
              state      <= ST_DROP;
            end else begin
              if (!count[0]) begin
                hold <= i_in_data;
              end
              count <= count + 1'b1;
            end
          end
          ST_DROP: begin
            if (i_in_eol) begin
              state <= ST_IDLE;
            end
          end
          default: begin
            state <= ST_IDLE;
            count <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lvds_line_buffer.sv
// Self-checking bench for lvds_line_buffer.
// A line-level model (queue of completed lines plus the line on screen)
// predicts handshake readiness, scan-out values and the sticky flags.
module tb_lvds_line_buffer;

  localparam int H  = 960;
  localparam int W  = 24;
  localparam int NP = 2*H;

  logic          clk = 1'b0;
  logic          i_reset;
  logic [W-1:0]  i_in_data;
  logic          i_in_valid;
  logic          o_in_ready;
  logic          i_in_sol;
  logic          i_in_eol;
  logic          i_line_start;
  logic [11:0]   i_x;
  logic [W-1:0]  o_color;
  logic [W-1:0]  o_color_even;
  logic          o_underflow;
  logic          o_sync_err;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] lines [0:7][0:NP-1];
  logic [W-1:0] cur   [0:NP-1];
  int           pending[$];
  int           shown = -1;
  int           next_id = 0;
  logic         exp_underflow = 1'b0;
  logic         exp_sync_err  = 1'b0;

  lvds_line_buffer #(.H_PAIRS(H), .PIX_W(W)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_in_data    (i_in_data),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .i_in_sol     (i_in_sol),
    .i_in_eol     (i_in_eol),
    .i_line_start (i_line_start),
    .i_x          (i_x),
    .o_color      (o_color),
    .o_color_even (o_color_even),
    .o_underflow  (o_underflow),
    .o_sync_err   (o_sync_err)
  );

  always #5 clk = ~clk;

  // Hard stop in case the whole run stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Free line slots: two banks shared by queued lines and the line on screen.
  function automatic logic exp_ready();
    int occupied;
    occupied = pending.size() + ((shown >= 0) ? 1 : 0);
    return (occupied < 2);
  endfunction

  function automatic logic [47:0] exp_pair(input int x);
    if (shown >= 0 && x < H) return {lines[shown][2*x], lines[shown][2*x+1]};
    return 48'h0;
  endfunction

  task automatic model_commit();
    int slot;
    slot = next_id % 8;
    for (int i = 0; i < NP; i++) lines[slot][i] = cur[i];
    pending.push_back(slot);
    next_id++;
  endtask

  task automatic model_line_start();
    if (pending.size() > 0) begin
      shown = pending.pop_front();
    end else begin
      shown = -1;
      exp_underflow = 1'b1;
    end
  endtask

  task automatic model_reset();
    pending.delete();
    shown = -1;
    exp_underflow = 1'b0;
    exp_sync_err  = 1'b0;
  endtask

  // Present one pixel and wait (bounded) until it is accepted.
  task automatic applyStimulus(input logic [W-1:0] d, input logic sol, input logic eol, input logic ls);
    int waited;
    waited = 0;
    @(negedge clk);
    i_in_data = d; i_in_sol = sol; i_in_eol = eol; i_in_valid = 1'b1; i_line_start = ls;
    #1;
    while (!o_in_ready && waited < 4000) begin
      @(negedge clk);
      i_line_start = 1'b0;
      waited++;
      #1;
    end
    if (!o_in_ready) checkOutput("ready_timeout", {63'h0, o_in_ready}, 64'h1);
    @(posedge clk);
  endtask

  task automatic go_idle();
    @(negedge clk);
    i_in_valid = 1'b0; i_in_sol = 1'b0; i_in_eol = 1'b0; i_line_start = 1'b0;
  endtask

  task automatic fill_cur(input bit rnd);
    for (int i = 0; i < NP; i++) cur[i] = rnd ? W'($urandom) : W'(i);
  endtask

  // Send pixels first..last of cur; sol on pixel 0, eol on eol_idx.
  task automatic send_range(input int first, input int last, input int eol_idx);
    for (int i = first; i <= last; i++) applyStimulus(cur[i], i == 0, i == eol_idx, 1'b0);
    go_idle();
  endtask

  task automatic pulse_line_start();
    @(negedge clk); i_line_start = 1'b1;
    @(negedge clk); i_line_start = 1'b0;
    model_line_start();
  endtask

  // Pipelined sweep: each slot index is checked one cycle after it is presented.
  task automatic sweep(input string tag);
    int xs [0:H+1];
    int prev;
    for (int k = 0; k < H; k++) xs[k] = k;
    xs[H] = H;
    xs[H+1] = 4095;
    prev = 0;
    for (int k = 0; k <= H+2; k++) begin
      @(negedge clk);
      if (k > 0) checkOutput(tag, {16'h0, o_color, o_color_even}, {16'h0, exp_pair(prev)});
      if (k <= H+1) begin
        i_x = 12'(xs[k]);
        prev = xs[k];
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    i_reset = 1'b1; i_in_valid = 1'b0; i_in_sol = 1'b0; i_in_eol = 1'b0; i_line_start = 1'b0;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    model_reset();
  endtask

  initial begin
    i_reset = 1'b1; i_in_data = '0; i_in_valid = 1'b0; i_in_sol = 1'b0;
    i_in_eol = 1'b0; i_line_start = 1'b0; i_x = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("reset_ready",     {63'h0, o_in_ready},  64'h0);
    checkOutput("reset_color",     {16'h0, o_color, o_color_even}, 64'h0);
    checkOutput("reset_underflow", {63'h0, o_underflow}, 64'h0);
    checkOutput("reset_sync_err",  {63'h0, o_sync_err},  64'h0);
    i_reset = 1'b0;
    model_reset();

    // Counting line, then display.
    $display("[TB] full line and sweep");
    fill_cur(1'b0);
    send_range(0, NP-1, NP-1);
    model_commit();
    pulse_line_start();
    sweep("sweep_count_line");
    checkOutput("count_underflow", {63'h0, o_underflow}, {63'h0, exp_underflow});

    // Back-pressure while both banks are occupied.
    $display("[TB] back-pressure");
    fill_cur(1'b1);
    send_range(0, NP-1, NP-1);
    model_commit();
    fill_cur(1'b1);
    @(negedge clk);
    i_in_data = cur[0]; i_in_sol = 1'b1; i_in_eol = 1'b0; i_in_valid = 1'b1;
    #1;
    checkOutput("ready_blocked", {63'h0, o_in_ready}, {63'h0, exp_ready()});
    i_line_start = 1'b1;
    @(negedge clk);
    i_line_start = 1'b0;
    model_line_start();
    #1;
    checkOutput("ready_after_ls", {63'h0, o_in_ready}, {63'h0, exp_ready()});
    @(posedge clk);
    send_range(1, NP-1, NP-1);
    model_commit();
    sweep("sweep_second_line");
    pulse_line_start();
    sweep("sweep_third_line");

    // Underflow with nothing buffered.
    $display("[TB] underflow");
    apply_reset();
    pulse_line_start();
    sweep("sweep_underflow");
    checkOutput("underflow_set", {63'h0, o_underflow}, {63'h0, exp_underflow});
    repeat (5) @(negedge clk);
    checkOutput("underflow_sticky", {63'h0, o_underflow}, {63'h0, exp_underflow});

    // Early end of line.
    $display("[TB] early eol");
    apply_reset();
    fill_cur(1'b1);
    send_range(0, 999, 999);
    exp_sync_err = 1'b1;
    checkOutput("early_eol_sync_err", {63'h0, o_sync_err}, {63'h0, exp_sync_err});
    pulse_line_start();
    @(negedge clk);
    checkOutput("early_eol_underflow", {63'h0, o_underflow}, {63'h0, exp_underflow});
    fill_cur(1'b1);
    send_range(0, NP-1, NP-1);
    model_commit();
    pulse_line_start();
    sweep("sweep_after_early_eol");
    checkOutput("early_eol_sync_sticky", {63'h0, o_sync_err}, {63'h0, exp_sync_err});

    // Line completion coinciding with line start.
    $display("[TB] completion with line start");
    apply_reset();
    fill_cur(1'b1);
    for (int i = 0; i < NP-1; i++) applyStimulus(cur[i], i == 0, 1'b0, 1'b0);
    applyStimulus(cur[NP-1], 1'b0, 1'b1, 1'b1);
    go_idle();
    model_line_start();
    model_commit();
    @(negedge clk);
    checkOutput("coincide_underflow", {63'h0, o_underflow}, {63'h0, exp_underflow});
    pulse_line_start();
    sweep("sweep_coincide_next");

    // Reset in the middle of a line.
    $display("[TB] reset mid-line");
    apply_reset();
    fill_cur(1'b1);
    send_range(0, 498, -1);
    @(negedge clk);
    i_in_data = cur[499]; i_in_valid = 1'b1; i_reset = 1'b1;
    #1;
    checkOutput("midreset_ready", {63'h0, o_in_ready}, 64'h0);
    @(negedge clk);
    checkOutput("midreset_color",     {16'h0, o_color, o_color_even}, 64'h0);
    checkOutput("midreset_underflow", {63'h0, o_underflow}, 64'h0);
    checkOutput("midreset_sync_err",  {63'h0, o_sync_err},  64'h0);
    i_reset = 1'b0;
    i_in_valid = 1'b0;
    model_reset();
    send_range(500, NP-1, NP-1);
    checkOutput("nosol_sync_err", {63'h0, o_sync_err}, {63'h0, exp_sync_err});
    pulse_line_start();
    sweep("sweep_nosol_discarded");
    fill_cur(1'b1);
    send_range(0, NP-1, NP-1);
    model_commit();
    pulse_line_start();
    sweep("sweep_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
